// File: rtl/pmu_seq_pkg.sv
// Shared types and constants for the PMU sample sequencer.
// The CLR states exist only when PMU_SAMPLE_CLEAR_EN is defined.
package pmu_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN_W,
        S_EN_B,
        S_WAIT,
        S_RD_A,
        S_RD_R,
        S_PUSH,
`ifdef PMU_SAMPLE_CLEAR_EN
        S_CLR_W,
        S_CLR_B,
`endif
        S_DIS_W,
        S_DIS_B
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // PMU main config words: bit0 enable, bit1 soft-reset counters
    localparam logic [31:0] CFG_ENABLE  = 32'h0000_0001;
    localparam logic [31:0] CFG_CLEAR   = 32'h0000_0003;
    localparam logic [31:0] CFG_DISABLE = 32'h0000_0000;

    function automatic logic [31:0] cnt_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/pmu_axil_wr_single.sv
// Single AXI4-Lite write: AW and W raised together on start, each dropped on its own
// handshake; sent pulses when both are accepted, done when the B response arrives.
module pmu_axil_wr_single
    import pmu_seq_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic                sent,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    logic resp_phase;
    logic aw_ok;
    logic w_ok;

    assign aw_ok  = !awvalid || awready;
    assign w_ok   = !wvalid || wready;
    assign sent   = (awvalid || wvalid) && aw_ok && w_ok;
    assign bready = resp_phase;
    assign done   = resp_phase && bvalid;
    assign err    = done && (bresp != RESP_OKAY);
    assign wstrb  = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            awaddr     <= '0;
            wdata      <= '0;
            resp_phase <= 1'b0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= addr;
            wdata   <= data;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (sent)               resp_phase <= 1'b1;
            else if (done)          resp_phase <= 1'b0;
        end
    end

endmodule

// File: rtl/pmu_sample_sequencer.sv
// Autonomous AXI4-Lite master that enables the PMU and sweeps all counters once per period.
// Define PMU_SAMPLE_CLEAR_EN to soft-reset the counters after each sweep (per-period deltas).
module pmu_sample_sequencer
    import pmu_seq_pkg::*;
#(
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter int                          C_M_AXI_ADDR_WIDTH = 7,
    parameter int                          N_COUNTERS         = 16,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_ADDR         = 7'h40,
    parameter int                          PERIOD_W           = 24
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              stop_i,
    input  logic [PERIOD_W-1:0]               period_i,
    output logic                              busy_o,
    output logic                              err_o,
    output logic                              smp_valid_o,
    input  logic                              smp_ready_i,
    output logic [$clog2(N_COUNTERS)-1:0]     smp_idx_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     smp_data_o,
    output logic                              smp_last_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR_o,
    output logic                              M_AXI_AWVALID_o,
    input  logic                              M_AXI_AWREADY_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA_o,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB_o,
    output logic                              M_AXI_WVALID_o,
    input  logic                              M_AXI_WREADY_i,
    input  logic [1:0]                        M_AXI_BRESP_i,
    input  logic                              M_AXI_BVALID_i,
    output logic                              M_AXI_BREADY_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR_o,
    output logic                              M_AXI_ARVALID_o,
    input  logic                              M_AXI_ARREADY_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA_i,
    input  logic [1:0]                        M_AXI_RRESP_i,
    input  logic                              M_AXI_RVALID_i,
    output logic                              M_AXI_RREADY_o
);

    localparam int IDX_W = $clog2(N_COUNTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COUNTERS - 1);

    state_t                          state, next;
    logic [IDX_W-1:0]                idx;
    logic [PERIOD_W-1:0]             period_r;
    logic [PERIOD_W-1:0]             cnt;
    logic                            load_cnt;
    logic                            wr_start;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data;
    logic                            wr_sent;
    logic                            wr_done;
    logic                            wr_err;
    logic                            push_hs;
    logic                            start_ok;

    assign push_hs  = (state == S_PUSH) && smp_ready_i;
    assign start_ok = (state == S_IDLE) && start_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next     = state;
        wr_start = 1'b0;
        wr_data  = C_M_AXI_DATA_WIDTH'(CFG_ENABLE);
        load_cnt = 1'b0;
        case (state)
            S_IDLE: if (start_i) begin
                next     = S_EN_W;
                wr_start = 1'b1;
            end
            S_EN_W: if (wr_sent) next = S_EN_B;
            S_EN_B: if (wr_done) begin
                next     = S_WAIT;
                load_cnt = 1'b1;
            end
            // stop has priority over an expiring period
            S_WAIT: if (stop_i) begin
                next     = S_DIS_W;
                wr_start = 1'b1;
                wr_data  = C_M_AXI_DATA_WIDTH'(CFG_DISABLE);
            end else if (cnt == '0) begin
                next = S_RD_A;
            end
            S_RD_A: if (M_AXI_ARREADY_i) next = S_RD_R;
            S_RD_R: if (M_AXI_RVALID_i) next = S_PUSH;
            S_PUSH: if (smp_ready_i) begin
                if (idx != LAST_IDX) begin
                    next = S_RD_A;
                end else begin
`ifdef PMU_SAMPLE_CLEAR_EN
                    next     = S_CLR_W;
                    wr_start = 1'b1;
                    wr_data  = C_M_AXI_DATA_WIDTH'(CFG_CLEAR);
`else
                    next     = S_WAIT;
                    load_cnt = 1'b1;
`endif
                end
            end
`ifdef PMU_SAMPLE_CLEAR_EN
            S_CLR_W: if (wr_sent) next = S_CLR_B;
            S_CLR_B: if (wr_done) begin
                next     = S_WAIT;
                load_cnt = 1'b1;
            end
`endif
            S_DIS_W: if (wr_sent) next = S_DIS_B;
            S_DIS_B: if (wr_done) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx        <= '0;
            period_r   <= '0;
            cnt        <= '0;
            smp_data_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (start_ok) period_r <= period_i;
            if (load_cnt)                       cnt <= period_r;
            else if (state == S_WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (state == S_RD_R && M_AXI_RVALID_i) smp_data_o <= M_AXI_RDATA_i;
            if (push_hs) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (start_ok)
                err_o <= 1'b0;
            else if (wr_err || (state == S_RD_R && M_AXI_RVALID_i && M_AXI_RRESP_i != RESP_OKAY))
                err_o <= 1'b1;
        end
    end

    assign busy_o          = (state != S_IDLE);
    assign smp_valid_o     = (state == S_PUSH);
    assign smp_idx_o       = idx;
    assign smp_last_o      = (state == S_PUSH) && (idx == LAST_IDX);
    assign M_AXI_ARVALID_o = (state == S_RD_A);
    assign M_AXI_ARADDR_o  = (state == S_RD_A) ? C_M_AXI_ADDR_WIDTH'(cnt_addr(32'(idx))) : '0;
    assign M_AXI_RREADY_o  = (state == S_RD_R);

    pmu_axil_wr_single #(
        .ADDR_W (C_M_AXI_ADDR_WIDTH),
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_wr (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (wr_start),
        .addr    (CFG_ADDR),
        .data    (wr_data),
        .sent    (wr_sent),
        .done    (wr_done),
        .err     (wr_err),
        .awaddr  (M_AXI_AWADDR_o),
        .awvalid (M_AXI_AWVALID_o),
        .awready (M_AXI_AWREADY_i),
        .wdata   (M_AXI_WDATA_o),
        .wstrb   (M_AXI_WSTRB_o),
        .wvalid  (M_AXI_WVALID_o),
        .wready  (M_AXI_WREADY_i),
        .bresp   (M_AXI_BRESP_i),
        .bvalid  (M_AXI_BVALID_i),
        .bready  (M_AXI_BREADY_o)
    );

endmodule

// File: tb/tb_pmu_sample_sequencer.sv
// Directed bench for pmu_sample_sequencer with a small AXI4-Lite PMU slave model
// (counter i reads as i*0x100); the sink handshakes each sample from the main thread.
module tb_pmu_sample_sequencer;

`ifdef PMU_SAMPLE_CLEAR_EN
    localparam int CLR_CYC = 2;
    localparam int CLR_WR  = 1;
`else
    localparam int CLR_CYC = 0;
    localparam int CLR_WR  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] period = '0;
    logic        busy, err, smp_valid, smp_last;
    logic        smp_ready = 1'b0;
    logic [3:0]  smp_idx;
    logic [31:0] smp_data;
    logic [6:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // slave model knobs (main thread) and state (slave process)
    int aw_lat = 0, w_lat = 0, err_idx = -1;
    int aw_age = 0, w_age = 0;
    logic aw_got = 1'b0, w_got = 1'b0;
    logic [6:0]  wa = '0, last_wa = '0;
    logic [31:0] wd = '0, last_wd = '0;
    int wr_cnt = 0, b_cnt = 0;
    int aw_dup = 0, w_hold = 0;

    always #5 clk = ~clk;

    pmu_sample_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .period_i(period),
        .busy_o(busy), .err_o(err), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready),
        .smp_idx_o(smp_idx), .smp_data_o(smp_data), .smp_last_o(smp_last),
        .M_AXI_AWADDR_o(awaddr), .M_AXI_AWVALID_o(awvalid), .M_AXI_AWREADY_i(awready),
        .M_AXI_WDATA_o(wdata), .M_AXI_WSTRB_o(wstrb), .M_AXI_WVALID_o(wvalid),
        .M_AXI_WREADY_i(wready), .M_AXI_BRESP_i(bresp), .M_AXI_BVALID_i(bvalid),
        .M_AXI_BREADY_o(bready), .M_AXI_ARADDR_o(araddr), .M_AXI_ARVALID_o(arvalid),
        .M_AXI_ARREADY_i(arready), .M_AXI_RDATA_i(rdata), .M_AXI_RRESP_i(rresp),
        .M_AXI_RVALID_i(rvalid), .M_AXI_RREADY_o(rready)
    );

    assign awready = awvalid && (aw_age >= aw_lat);
    assign wready  = wvalid && (w_age >= w_lat);
    assign arready = arvalid;
    assign bresp   = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            aw_age <= 0; w_age <= 0; rdata <= '0; rresp <= 2'b00;
        end else begin
            aw_age <= (awvalid && !awready) ? aw_age + 1 : 0;
            w_age  <= (wvalid && !wready) ? w_age + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; wa <= awaddr; end
            if (wvalid && wready)   begin w_got <= 1'b1; wd <= wdata; end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_cnt + 1;
            end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid  <= 1'b1;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= (awvalid && awready) ? awaddr : wa;
                last_wd <= (wvalid && wready) ? wdata : wd;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= {20'h0, araddr[5:2], 8'h00};
                rresp  <= (int'(araddr[5:2]) == err_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        if (awvalid && aw_got) aw_dup <= aw_dup + 1;
        if (wvalid && aw_got && !w_got) w_hold <= w_hold + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic take(input int hold, output int idx, output logic [31:0] data,
                        output logic last, output int at, output int bad);
        int n = 0;
        bad = 0;
        @(negedge clk);
        while (!smp_valid && n < 300) begin @(negedge clk); n++; end
        check("smp_valid_timeout", 32'(smp_valid), 32'd1);
        idx = int'(smp_idx); data = smp_data; last = smp_last;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!smp_valid || int'(smp_idx) != idx || smp_data != data || arvalid) bad++;
        end
        at = cyc;
        smp_ready = 1'b1;
        @(posedge clk); #1;
        smp_ready = 1'b0;
    endtask

    task automatic sweep(input int hold_at, input int hold_len, input int rerr,
                         output int t_first, output int t_last);
        int idx, at, prev, bad;
        logic [31:0] d;
        logic last;
        prev = 0; at = 0; t_first = 0;
        for (int i = 0; i < 16; i++) begin
            take((i == hold_at) ? hold_len : 0, idx, d, last, at, bad);
            check($sformatf("smp_idx[%0d]", i), 32'(idx), 32'(i));
            check($sformatf("smp_data[%0d]", i), d, 32'(i * 256));
            check($sformatf("smp_last[%0d]", i), 32'(last), 32'(i == 15));
            if (i == 0) t_first = at;
            if (i == 1) check("sweep_spacing", 32'(at - prev), 32'd3);
            if (i == hold_at) check("stall_stable_no_ar", 32'(bad), 32'd0);
            if (rerr >= 0 && i == rerr - 1) check("err_before_rresp", 32'(err), 32'd0);
            if (rerr >= 0 && i == rerr) check("err_on_rresp", 32'(err), 32'd1);
            prev = at;
        end
        t_last = at;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int f1, l1, f2, l2, f3, l3, n, wr_base, b_base, wh_base;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_axi_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 0);
        check("rst_smp", 32'({smp_valid, smp_last, smp_idx}), 0);
        check("rst_smp_data", smp_data, 0);
        check("wstrb", 32'(wstrb), 32'hF);
        rst = 1'b0;

        // sweep 1/2 with period 10; period_i changed after start must not matter
        period = 24'd10;
        pulse_start();
        period = 24'd5;
        sweep(-1, 0, -1, f1, l1);
        check("en_wr_cnt", 32'(wr_cnt), 1);
        check("en_wr_addr", 32'(last_wa), 32'h40);
        check("en_wr_data", last_wd, 32'h1);
`ifdef PMU_SAMPLE_CLEAR_EN
        repeat (4) @(posedge clk);
        #1;
        check("clr_wr_data", last_wd, 32'h3);
        check("clr_wr_addr", 32'(last_wa), 32'h40);
`endif
        err_idx = 7;
        sweep(5, 20, 7, f2, l2);
        err_idx = -1;
        check("period10_gap", 32'(f2 - l1), 32'(14 + CLR_CYC));
        check("err_sticky", 32'(err), 1);

        // sweep 3: start while busy ignored, stop held from mid-sweep until seen in WAIT
        fork
            sweep(-1, 0, -1, f3, l3);
            begin
                repeat (20) @(posedge clk);
                #1;
                pulse_start();
                check("busy_start_keeps_err", 32'(err), 1);
                stop = 1'b1;
            end
        join
        wr_base = wr_cnt;
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("stop_busy_fall", 32'(busy), 0);
        check("dis_wr_cnt", 32'(wr_cnt - wr_base), 32'(1 + CLR_WR));
        check("dis_wr_addr", 32'(last_wa), 32'h40);
        check("dis_wr_data", last_wd, 32'h0);
        check("stop_no_sample", 32'(smp_valid), 0);
        stop = 1'b0;
        @(posedge clk); #1;

        // restart: AW accepted 3 cycles before W, period 0
        aw_lat = 0; w_lat = 3; period = 24'd0;
        wr_base = wr_cnt; b_base = b_cnt; wh_base = w_hold;
        pulse_start();
        check("start_clears_err", 32'(err), 0);
        check("start_busy", 32'(busy), 1);
        n = 0;
        while (wr_cnt == wr_base && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(posedge clk);
        #1;
        check("split_wr_cnt", 32'(wr_cnt - wr_base), 1);
        check("split_b_cnt", 32'(b_cnt - b_base), 1);
        check("split_aw_dup", 32'(aw_dup), 0);
        check("split_w_hold", 32'(w_hold - wh_base), 3);
        check("split_wr_data", last_wd, 32'h1);
        w_lat = 0;
        sweep(-1, 0, -1, f1, l1);
        sweep(-1, 0, -1, f2, l2);
        check("period0_gap", 32'(f2 - l1), 32'(4 + CLR_CYC));

        // reset while waiting for read data
        n = 0;
        @(negedge clk);
        while (!rready && n < 50) begin @(negedge clk); n++; end
        check("reach_rd_r", 32'(rready), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rd_r_busy", 32'(busy), 0);
        check("rst_rd_r_valids", 32'({awvalid, wvalid, arvalid, bready, rready, smp_valid}), 0);
        check("rst_rd_r_smp", 32'({smp_last, smp_idx}), 0);
        check("rst_rd_r_data", smp_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
        $fatal(1, "timeout");
    end

endmodule
